// File: rtl/sbox_share_sched.sv
// Shares one bank of NUM_SBOX S-box lanes between a 128-bit round SubBytes and a 32-bit SubWord.
// Define SBOX_SHARE_PERF_EN to add the busy-cycle and conflict performance counters.
module sbox_share_sched #(
    parameter int unsigned NUM_SBOX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  rnd_valid_i,
    output logic                  rnd_ready_o,
    input  logic [127:0]          rnd_data_i,
    output logic                  rnd_out_valid_o,
    output logic [127:0]          rnd_out_o,
    input  logic                  key_valid_i,
    output logic                  key_ready_o,
    input  logic [31:0]           key_word_i,
    output logic                  key_out_valid_o,
    output logic [31:0]           key_out_o,
    output logic [8*NUM_SBOX-1:0] sb_in_o,
    input  logic [8*NUM_SBOX-1:0] sb_out_i,
    output logic                  sb_en_o,
    output logic                  busy_o
`ifdef SBOX_SHARE_PERF_EN
    ,
    output logic [31:0]           perf_busy_cyc_o,
    output logic [15:0]           perf_conflict_o
`endif
);

    localparam int unsigned W         = 8 * NUM_SBOX;
    localparam int unsigned RND_BEATS = 16 / NUM_SBOX;
    localparam int unsigned KEY_BEATS = 4 / NUM_SBOX;

    if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4)) begin : g_bad_num_sbox
        $error("sbox_share_sched: NUM_SBOX must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {StIdle, StRnd, StKey, StDone} state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           last_key_q, last_key_d;
    logic [127:0]   op_q, op_d;
    logic [127:0]   rnd_res_q, rnd_res_d;
    logic [31:0]    key_res_q, key_res_d;

    logic [6:0]     shamt;
    logic [127:0]   op_sh, ins, mask;
    logic           idle;

    // Beat k works on bytes k*NUM_SBOX.. counted from the MSB, so everything is a left-aligned shift.
    assign shamt = 7'(cnt_q * W);
    assign op_sh = op_q << shamt;
    assign ins   = {sb_out_i, {(128 - W){1'b0}}} >> shamt;
    assign mask  = {{W{1'b1}}, {(128 - W){1'b0}}} >> shamt;

    assign idle        = (state_q == StIdle);
    assign busy_o      = !idle;
    assign rnd_ready_o = idle & !flush_i & rnd_valid_i & (!key_valid_i | last_key_q);
    assign key_ready_o = idle & !flush_i & key_valid_i & (!rnd_valid_i | !last_key_q);
    assign sb_en_o     = (state_q == StRnd) || (state_q == StKey);
    assign sb_in_o     = sb_en_o ? op_sh[127 -: W] : '0;

    assign rnd_out_valid_o = (state_q == StDone) & !last_key_q & !flush_i;
    assign key_out_valid_o = (state_q == StDone) & last_key_q & !flush_i;
    assign rnd_out_o       = rnd_res_q;
    assign key_out_o       = key_res_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_key_d = last_key_q;
        op_d       = op_q;
        rnd_res_d  = rnd_res_q;
        key_res_d  = key_res_q;
        unique case (state_q)
            StIdle: begin
                if (rnd_ready_o) begin
                    op_d       = rnd_data_i;
                    last_key_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = StRnd;
                end else if (key_ready_o) begin
                    op_d       = {key_word_i, 96'h0};
                    last_key_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = StKey;
                end
            end
            StRnd: begin
                rnd_res_d = (rnd_res_q & ~mask) | ins;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'(RND_BEATS - 1)) state_d = StDone;
            end
            StKey: begin
                key_res_d = (key_res_q & ~mask[127:96]) | ins[127:96];
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'(KEY_BEATS - 1)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Abort discards the in-flight operation but keeps arbitration history.
        if (flush_i) begin
            state_d    = StIdle;
            cnt_d      = '0;
            last_key_d = last_key_q;
            op_d       = op_q;
            rnd_res_d  = rnd_res_q;
            key_res_d  = key_res_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_key_q <= 1'b0;
            op_q       <= '0;
            rnd_res_q  <= '0;
            key_res_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_key_q <= last_key_d;
            op_q       <= op_d;
            rnd_res_q  <= rnd_res_d;
            key_res_q  <= key_res_d;
        end
    end

`ifdef SBOX_SHARE_PERF_EN
    logic conflict;
    assign conflict = (rnd_valid_i & key_valid_i & !rnd_ready_o & !key_ready_o) |
                      ((rnd_valid_i | key_valid_i) & busy_o);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_busy_cyc_o <= '0;
            perf_conflict_o <= '0;
        end else begin
            if (busy_o && !(&perf_busy_cyc_o)) perf_busy_cyc_o <= perf_busy_cyc_o + 32'd1;
            if (conflict && !(&perf_conflict_o)) perf_conflict_o <= perf_conflict_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sbox_share_sched.sv
// Directed bench: three instances (NUM_SBOX = 4, 2, 1) each with a real AES S-box bank.
module tb_sbox_share_sched;

    logic clk, rst_n, flush;
    logic rnd_valid, key_valid;
    logic [127:0] rnd_data;
    logic [31:0]  key_word;

    logic rr4, rov4, kr4, kov4, en4, busy4;
    logic [127:0] ro4;
    logic [31:0]  ko4, si4, so4;
    logic rr2, rov2, kr2, kov2, en2, busy2;
    logic [127:0] ro2;
    logic [31:0]  ko2;
    logic [15:0]  si2, so2;
    logic rr1, rov1, kr1, kov1, en1, busy1;
    logic [127:0] ro1;
    logic [31:0]  ko1;
    logic [7:0]   si1, so1;

    int total = 0;
    int bad = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, base, e, s;
        r = 8'h01;
        base = x;
        e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, base);
            base = gmul(base, base);
        end
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

    assign so4 = {sbox(si4[31:24]), sbox(si4[23:16]), sbox(si4[15:8]), sbox(si4[7:0])};
    assign so2 = {sbox(si2[15:8]), sbox(si2[7:0])};
    assign so1 = sbox(si1);

    sbox_share_sched #(.NUM_SBOX(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .rnd_valid_i(rnd_valid), .rnd_ready_o(rr4), .rnd_data_i(rnd_data),
        .rnd_out_valid_o(rov4), .rnd_out_o(ro4),
        .key_valid_i(key_valid), .key_ready_o(kr4), .key_word_i(key_word),
        .key_out_valid_o(kov4), .key_out_o(ko4),
        .sb_in_o(si4), .sb_out_i(so4), .sb_en_o(en4), .busy_o(busy4)
    );
    sbox_share_sched #(.NUM_SBOX(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .rnd_valid_i(rnd_valid), .rnd_ready_o(rr2), .rnd_data_i(rnd_data),
        .rnd_out_valid_o(rov2), .rnd_out_o(ro2),
        .key_valid_i(key_valid), .key_ready_o(kr2), .key_word_i(key_word),
        .key_out_valid_o(kov2), .key_out_o(ko2),
        .sb_in_o(si2), .sb_out_i(so2), .sb_en_o(en2), .busy_o(busy2)
    );
    sbox_share_sched #(.NUM_SBOX(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .rnd_valid_i(rnd_valid), .rnd_ready_o(rr1), .rnd_data_i(rnd_data),
        .rnd_out_valid_o(rov1), .rnd_out_o(ro1),
        .key_valid_i(key_valid), .key_ready_o(kr1), .key_word_i(key_word),
        .key_out_valid_o(kov1), .key_out_o(ko1),
        .sb_in_o(si1), .sb_out_i(so1), .sb_en_o(en1), .busy_o(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for a result pulse on the NUM_SBOX=4 instance; cyc is cycles since the accept edge.
    task automatic wait4(input bit is_key, output int cyc);
        cyc = 1;
        while (!(is_key ? kov4 : rov4) && cyc < 40) begin
            tick();
            cyc++;
        end
        if (cyc >= 40) chk("wait4_timeout", 1, 0);
    endtask

    typedef struct {
        logic         is_key;
        logic [127:0] data;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lat4, lat2, lat1, np4, np2, np1, oth4, en_cnt4, cyc;
        logic [127:0] r4, r2, r1, v;
        int base;

        vecs[0] = '{1'b0, 128'h0, {16{8'h63}}};
        vecs[1] = '{1'b1, 128'hcf4f3c09, 128'h8a84eb01};
        vecs[2] = '{1'b0, {16{8'hff}}, {16{8'h16}}};
        vecs[3] = '{1'b1, 128'h00010253, 128'h637c77ed};
        vecs[4] = '{1'b0, 128'h00112233445566778899aabbccddeeff,
                    128'h638293c31bfc33f5c4eeacea4bc12816};

        rst_n = 1'b0; flush = 1'b0; rnd_valid = 1'b0; key_valid = 1'b0;
        rnd_data = '0; key_word = '0;
        tick();
        tick();
        chk("rst_busy", busy4, 0);
        chk("rst_rnd_out", ro4, 0);
        chk("rst_key_out", ko4, 0);
        chk("rst_sb_in", si4, 0);
        chk("rst_sb_en", en4, 0);
        chk("rst_valids", {rov4, kov4}, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].is_key) begin
                key_valid = 1'b1;
                key_word = vecs[i].data[31:0];
            end else begin
                rnd_valid = 1'b1;
                rnd_data = vecs[i].data;
            end
            #1;
            chk($sformatf("v%0d_ready", i), vecs[i].is_key ? {kr4, kr2, kr1, rr4}
                                                          : {rr4, rr2, rr1, kr4}, 4'b1110);
            tick();
            rnd_valid = 1'b0;
            key_valid = 1'b0;
            rnd_data = {8{16'hdead}};
            key_word = 32'hbeef1234;
            lat4 = 0; lat2 = 0; lat1 = 0; np4 = 0; np2 = 0; np1 = 0; oth4 = 0; en_cnt4 = 0;
            r4 = '0; r2 = '0; r1 = '0;
            for (int c = 1; c <= 20; c++) begin
                if (en4) en_cnt4++;
                if (vecs[i].is_key ? rov4 : kov4) oth4++;
                if (vecs[i].is_key ? kov4 : rov4) begin
                    np4++; lat4 = c; r4 = vecs[i].is_key ? {96'h0, ko4} : ro4;
                end
                if (vecs[i].is_key ? kov2 : rov2) begin
                    np2++; lat2 = c; r2 = vecs[i].is_key ? {96'h0, ko2} : ro2;
                end
                if (vecs[i].is_key ? kov1 : rov1) begin
                    np1++; lat1 = c; r1 = vecs[i].is_key ? {96'h0, ko1} : ro1;
                end
                tick();
            end
            base = vecs[i].is_key ? 4 : 16;
            chk($sformatf("v%0d_lat4", i), lat4, base / 4 + 1);
            chk($sformatf("v%0d_lat2", i), lat2, base / 2 + 1);
            chk($sformatf("v%0d_lat1", i), lat1, base + 1);
            chk($sformatf("v%0d_pulses", i), {np4[3:0], np2[3:0], np1[3:0]}, 12'h111);
            chk($sformatf("v%0d_other_valid", i), oth4, 0);
            chk($sformatf("v%0d_sb_en_cnt", i), en_cnt4, base / 4);
            chk($sformatf("v%0d_data4", i), r4, vecs[i].exp);
            chk($sformatf("v%0d_data2", i), r2, vecs[i].exp);
            chk($sformatf("v%0d_data1", i), r1, vecs[i].exp);
            chk($sformatf("v%0d_hold4", i), vecs[i].is_key ? {96'h0, ko4} : ro4, vecs[i].exp);
        end

        // Tie right after reset goes to KEY, the next tie goes to RND.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rnd_valid = 1'b1; rnd_data = {16{8'hff}};
        key_valid = 1'b1; key_word = 32'h00010253;
        #1;
        chk("tie1_ready4", {kr4, rr4}, 2'b10);
        chk("tie1_ready21", {kr2, rr2, kr1, rr1}, 4'b1010);
        tick();
        wait4(1'b1, cyc);
        chk("tie1_key_lat", cyc, 2);
        chk("tie1_key_out", ko4, 32'h637c77ed);
        tick();
        chk("tie2_ready4", {kr4, rr4}, 2'b01);
        tick();
        rnd_valid = 1'b0;
        wait4(1'b0, cyc);
        chk("tie2_rnd_lat", cyc, 5);
        chk("tie2_rnd_out", ro4, {16{8'h16}});
        tick();
        chk("tie3_key_ready4", kr4, 1);
        key_valid = 1'b0;
        repeat (4) tick();

        // Flush in the third beat of a round op, with a key request waiting.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rnd_valid = 1'b1; rnd_data = '0;
        tick();
        rnd_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1; key_valid = 1'b1; key_word = 32'hcf4f3c09;
        #1;
        chk("fl_ready_low", {kr4, rr4}, 2'b00);
        chk("fl_in_beat", {en4, busy4}, 2'b11);
        tick();
        chk("fl_busy_after", busy4, 0);
        flush = 1'b0;
        #1;
        chk("fl_key_ready", kr4, 1);
        tick();
        key_valid = 1'b0;
        np4 = 0; np2 = 0; r4 = '0;
        for (int c = 0; c < 8; c++) begin
            if (rov4) np4++;
            if (kov4) begin
                np2++; r4 = {96'h0, ko4};
            end
            tick();
        end
        chk("fl_no_rnd_valid", np4, 0);
        chk("fl_key_pulses", np2, 1);
        chk("fl_key_out", r4, 128'h8a84eb01);

        // Flush landing in DONE suppresses the pulse.
        key_valid = 1'b1; key_word = 32'h00010253;
        tick();
        key_valid = 1'b0;
        tick();
        flush = 1'b1;
        #1;
        chk("fld_in_done", busy4, 1);
        chk("fld_no_pulse", kov4, 0);
        tick();
        flush = 1'b0;
        chk("fld_idle", {busy4, kov4}, 2'b00);
        tick();

        // Asynchronous reset mid-KEY.
        key_valid = 1'b1; key_word = 32'h01020304;
        tick();
        key_valid = 1'b0;
        v = {rov4, kov4, en4, busy4};
        chk("rk_in_key", v, 4'b0011);
        rst_n = 1'b0;
        #1;
        chk("rk_busy", busy4, 0);
        chk("rk_sb", {en4, si4}, 0);
        chk("rk_outs", {ro4, ko4}, 0);
        chk("rk_valids", {rov4, kov4}, 0);
        tick();
        rst_n = 1'b1;
        rnd_valid = 1'b1; rnd_data = '0;
        key_valid = 1'b1; key_word = 32'hcf4f3c09;
        #1;
        chk("rk_tie_key", {kr4, rr4}, 2'b10);
        tick();
        rnd_valid = 1'b0; key_valid = 1'b0;
        wait4(1'b1, cyc);
        chk("rk_key_lat", cyc, 2);
        chk("rk_key_out", ko4, 32'h8a84eb01);
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
